iobus_interval_timer: RTL and testbench

Memory-mapped interval timer on the MCU IOBUS that generates the one-cycle interrupt pulse feeding the MCU `INTR` input. It is a peer of the LEDS/SSEG/switch peripherals and runs on the MCU clock (`sclk`). Software programs a reload value and a mode, then the block counts down in prescaled ticks, flags expiry in a status register and pulses `INTR`. It is instantiated in the top-level wrapper; its read data is OR-ed into the IOBUS input mux.

---
 rtl/otter_io_pkg.sv | 24 ++
 rtl/tick_prescaler.sv | 32 +++
 rtl/iobus_interval_timer.sv | 147 ++++++++++++++
 tb/tb_iobus_interval_timer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_io_pkg.sv
// Shared IOBUS peripheral definitions: interval timer register offsets,
// CTRL bit positions and the timer state encoding.
package otter_io_pkg;

    localparam logic [3:0] TMR_CTRL_OFS   = 4'h0;
    localparam logic [3:0] TMR_RELOAD_OFS = 4'h4;
    localparam logic [3:0] TMR_COUNT_OFS  = 4'h8;
    localparam logic [3:0] TMR_STATUS_OFS = 4'hC;

    localparam int TMR_CTRL_W        = 3;
    localparam int TMR_CTRL_EN_BIT   = 0;
    localparam int TMR_CTRL_AUTO_BIT = 1;
    localparam int TMR_CTRL_IE_BIT   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_t;

    function automatic logic [31:0] tmr_addr(input logic [31:0] base, input logic [3:0] ofs);
        return base + {28'd0, ofs};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK down to a one-cycle tick every PRESCALE cycles while running.
// The phase counter restarts from zero on clear and rests at zero when stopped.
module tick_prescaler #(
    parameter int PRESCALE = 50
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (clear || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = run && !clear && (r_cnt == LAST);

endmodule

// File: rtl/iobus_interval_timer.sv
// IOBUS interval timer: programmable reload down-counter in prescaled ticks,
// sticky PEND status and a registered one-cycle INTR pulse on expiry.
module iobus_interval_timer
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_AD  = 32'h11800000,
    parameter int          PRESCALE = 50
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_RD_DATA,
    output logic        INTR,
    output tmr_state_t  o_dbg_state
);

    tmr_state_t r_state;
    tmr_state_t w_state_nx;

    logic [TMR_CTRL_W-1:0] r_ctrl;
    logic [31:0]           r_reload;
    logic [31:0]           r_count;
    logic                  r_pend;
    logic                  r_intr;

    logic w_sel_ctrl, w_sel_reload, w_sel_count, w_sel_status;
    logic w_wr_ctrl, w_wr_reload, w_wr_status;
    logic w_tick;
    logic w_load, w_expire, w_decrement;

    assign w_sel_ctrl   = (IOBUS_ADDR == tmr_addr(BASE_AD, TMR_CTRL_OFS));
    assign w_sel_reload = (IOBUS_ADDR == tmr_addr(BASE_AD, TMR_RELOAD_OFS));
    assign w_sel_count  = (IOBUS_ADDR == tmr_addr(BASE_AD, TMR_COUNT_OFS));
    assign w_sel_status = (IOBUS_ADDR == tmr_addr(BASE_AD, TMR_STATUS_OFS));

    assign w_wr_ctrl   = IOBUS_WR && w_sel_ctrl;
    assign w_wr_reload = IOBUS_WR && w_sel_reload;
    assign w_wr_status = IOBUS_WR && w_sel_status;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .CLK  (CLK),
        .RESET(RESET),
        .clear(w_wr_ctrl),
        .run  (r_state == RUN),
        .tick (w_tick)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // A CTRL write pre-empts any tick in the same cycle, so a restart or stop
    // on the expiry cycle produces neither PEND nor INTR.
    always_comb begin
        w_state_nx  = r_state;
        w_load      = 1'b0;
        w_expire    = 1'b0;
        w_decrement = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wr_ctrl && IOBUS_OUT[TMR_CTRL_EN_BIT]) begin
                    w_state_nx = RUN;
                    w_load     = 1'b1;
                end
            end
            RUN: begin
                if (w_wr_ctrl) begin
                    if (IOBUS_OUT[TMR_CTRL_EN_BIT]) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else if (w_tick) begin
                    if (r_count == 32'd0) begin
                        w_expire = 1'b1;
                        if (!r_ctrl[TMR_CTRL_AUTO_BIT]) begin
                            w_state_nx = IDLE;
                        end
                    end else begin
                        w_decrement = 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ctrl   <= '0;
            r_reload <= '0;
            r_count  <= '0;
            r_pend   <= 1'b0;
            r_intr   <= 1'b0;
        end else begin
            r_intr <= w_expire && r_ctrl[TMR_CTRL_IE_BIT];

            if (w_wr_ctrl) begin
                r_ctrl <= IOBUS_OUT[TMR_CTRL_W-1:0];
            end else if (w_expire && !r_ctrl[TMR_CTRL_AUTO_BIT]) begin
                r_ctrl[TMR_CTRL_EN_BIT] <= 1'b0;
            end

            if (w_wr_reload) begin
                r_reload <= IOBUS_OUT;
            end

            // Reload samples the register before any same-cycle RELOAD write.
            if (w_load || (w_expire && r_ctrl[TMR_CTRL_AUTO_BIT])) begin
                r_count <= r_reload;
            end else if (w_decrement) begin
                r_count <= r_count - 32'd1;
            end

            if (w_expire) begin
                r_pend <= 1'b1;
            end else if (w_wr_status && IOBUS_OUT[0]) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        IOBUS_RD_DATA = '0;
        if (w_sel_ctrl) begin
            IOBUS_RD_DATA = {{(32 - TMR_CTRL_W){1'b0}}, r_ctrl};
        end else if (w_sel_reload) begin
            IOBUS_RD_DATA = r_reload;
        end else if (w_sel_count) begin
            IOBUS_RD_DATA = r_count;
        end else if (w_sel_status) begin
            IOBUS_RD_DATA = {31'd0, r_pend};
        end
    end

    assign INTR        = r_intr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_iobus_interval_timer.sv
// Directed and randomized checks of the interval timer against a tick-level
// behavioural model of the register map.
module tb_iobus_interval_timer;
    import otter_io_pkg::*;

    localparam logic [31:0] B = 32'h11800000;
    localparam int          P = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_RD_DATA;
    logic        INTR;
    tmr_state_t  dbg_state;

    iobus_interval_timer #(
        .BASE_AD (B),
        .PRESCALE(P)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IOBUS_ADDR   (IOBUS_ADDR),
        .IOBUS_OUT    (IOBUS_OUT),
        .IOBUS_WR     (IOBUS_WR),
        .IOBUS_RD_DATA(IOBUS_RD_DATA),
        .INTR         (INTR),
        .o_dbg_state  (dbg_state)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errs   = 0;

    // Behavioural model: EN doubles as the running flag, phase counts CLK
    // cycles within a tick.
    logic [2:0]  m_ctrl;
    logic [31:0] m_reload;
    logic [31:0] m_count;
    logic        m_pend;
    logic        m_intr;
    int          m_phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_reload = '0; m_count = '0;
        m_pend = 1'b0; m_intr = 1'b0; m_phase = 0;
    endtask

    function automatic bit will_expire();
        return m_ctrl[0] && (m_phase == P - 1) && (m_count == 0);
    endfunction

    task automatic model_edge(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        bit cw, rw, sw, expired;
        cw = wr && (addr == B);
        rw = wr && (addr == B + 4);
        sw = wr && (addr == B + 12);
        expired = 0;
        m_intr = 1'b0;
        if (cw) begin
            m_ctrl = data[2:0];
            m_phase = 0;
            if (data[0]) m_count = m_reload;
        end else if (m_ctrl[0]) begin
            if (m_phase == P - 1) begin
                m_phase = 0;
                if (m_count != 0) begin
                    m_count = m_count - 1;
                end else begin
                    expired = 1;
                    m_intr = m_ctrl[2];
                    if (m_ctrl[1]) m_count = m_reload;
                    else m_ctrl[0] = 1'b0;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end
        if (expired) m_pend = 1'b1;
        else if (sw && data[0]) m_pend = 1'b0;
        if (rw) m_reload = data;
    endtask

    task automatic cycle(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        IOBUS_WR = wr; IOBUS_ADDR = addr; IOBUS_OUT = data;
        model_edge(wr, addr, data);
        @(posedge CLK); #1;
        IOBUS_WR = 1'b0;
        chk("intr", {31'd0, INTR}, {31'd0, m_intr});
        chk("state", {31'd0, dbg_state}, {31'd0, m_ctrl[0]});
    endtask

    task automatic idle();
        cycle(1'b0, B + 8, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        IOBUS_ADDR = addr;
        #1;
        chk(tag, IOBUS_RD_DATA, exp);
    endtask

    task automatic check_all(input string tag);
        rd_chk({tag, "_ctrl"},   B,      {29'd0, m_ctrl});
        rd_chk({tag, "_reload"}, B + 4,  m_reload);
        rd_chk({tag, "_count"},  B + 8,  m_count);
        rd_chk({tag, "_status"}, B + 12, {31'd0, m_pend});
    endtask

    initial begin
        int first, second, pulses, seen;
        logic [31:0] d;
        model_reset();

        // Reset values
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        chk("reset_intr", {31'd0, INTR}, 32'd0);
        rd_chk("reset_ctrl", B, 32'd0);
        rd_chk("reset_reload", B + 4, 32'd0);
        rd_chk("reset_count", B + 8, 32'd0);
        rd_chk("reset_status", B + 12, 32'd0);
        rd_chk("unmapped", 32'h1180_0010, 32'd0);

        // One-shot with IE: pulse 16 cycles after the CTRL write
        cycle(1, B + 4, 32'd3);
        cycle(1, B, 32'd5);
        first = 0;
        for (int i = 1; i <= 40 && first == 0; i++) begin
            idle();
            if (INTR) first = i;
        end
        chk("oneshot_latency", first, 32'd16);
        rd_chk("oneshot_ctrl", B, 32'd4);
        rd_chk("oneshot_pend", B + 12, 32'd1);
        pulses = 0;
        repeat (100) begin
            idle();
            if (INTR) pulses++;
        end
        chk("oneshot_no_more", pulses, 32'd0);
        check_all("oneshot_after");

        // Auto-reload, period 8: COUNT 1,0,1,0 on tick boundaries
        cycle(1, B + 12, 32'd1);
        cycle(1, B + 4, 32'd1);
        cycle(1, B, 32'd7);
        rd_chk("auto_count_start", B + 8, 32'd1);
        pulses = 0;
        for (int i = 1; i <= 32; i++) begin
            idle();
            if (INTR) begin
                pulses++;
                chk("auto_intr_phase", i % 8, 32'd0);
            end
            if (i % 4 == 0 && i <= 12)
                rd_chk("auto_count_seq", B + 8, ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
        end
        chk("auto_pulses", pulses, 32'd4);

        // Auto mode, IE=0: PEND without INTR, clear, set-wins collision
        cycle(1, B + 12, 32'd1);
        cycle(1, B + 4, 32'd2);
        cycle(1, B, 32'd3);
        pulses = 0;
        repeat (60) begin
            idle();
            if (INTR) pulses++;
        end
        chk("noie_pulses", pulses, 32'd0);
        rd_chk("noie_pend", B + 12, 32'd1);
        cycle(1, B + 12, 32'd1);
        rd_chk("noie_cleared", B + 12, 32'd0);
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            if (will_expire()) seen = 1;
            else idle();
        end
        chk("collide_found", seen, 32'd1);
        cycle(1, B + 12, 32'd1);
        rd_chk("collide_pend_wins", B + 12, 32'd1);

        // RELOAD 3 -> 7 mid-run: periods of 16 then 32 cycles
        cycle(1, B + 4, 32'd3);
        cycle(1, B, 32'd7);
        repeat (5) idle();
        cycle(1, B + 4, 32'd7);
        first = 0; second = 0;
        for (int i = 7; i <= 80 && second == 0; i++) begin
            idle();
            if (INTR) begin
                if (first == 0) first = i;
                else second = i;
            end
        end
        chk("reload_first", first, 32'd16);
        chk("reload_second", second, 32'd48);
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            if (will_expire()) seen = 1;
            else idle();
        end
        chk("ctrl_collide_found", seen, 32'd1);
        cycle(1, B, 32'd7);
        chk("ctrl_collide_no_intr", {31'd0, INTR}, 32'd0);
        first = 0;
        for (int i = 1; i <= 50 && first == 0; i++) begin
            idle();
            if (INTR) first = i;
        end
        chk("restart_period", first, 32'd32);

        // Asynchronous reset while INTR is high and mid-count
        cycle(1, B + 4, 32'd1);
        cycle(1, B, 32'd7);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            idle();
            if (INTR) seen = 1;
        end
        chk("pre_reset_pulse", seen, 32'd1);
        #2 RESET = 1'b1;
        model_reset();
        #1 chk("async_intr", {31'd0, INTR}, 32'd0);
        check_all("async");
        @(posedge CLK); #1 RESET = 1'b0;
        pulses = 0;
        repeat (50) begin
            idle();
            if (INTR) pulses++;
        end
        chk("post_reset_quiet", pulses, 32'd0);
        check_all("post_reset");
        cycle(1, B, 32'd5);
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            idle();
            if (INTR) first = i;
        end
        chk("resume_reload0", first, 32'd4);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 11))
                0: begin d = $urandom; if ($urandom_range(0, 1) == 1) d[0] = 1'b1; cycle(1, B, d); end
                1: cycle(1, B + 4, $urandom_range(0, 5));
                2: cycle(1, B + 12, $urandom);
                3: cycle(1, B + 8, $urandom);
                4: cycle(1, B + 16, $urandom);
                default: idle();
            endcase
            case ($urandom_range(0, 4))
                0: rd_chk("rnd_ctrl", B, {29'd0, m_ctrl});
                1: rd_chk("rnd_reload", B + 4, m_reload);
                2: rd_chk("rnd_count", B + 8, m_count);
                3: rd_chk("rnd_status", B + 12, {31'd0, m_pend});
                default: rd_chk("rnd_unmapped", B + 1, 32'd0);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
